branch_fwd_ctrl: RTL and testbench

- Producer of the branch-compare forwarding selects (b_r1_fwd_s4, b_r2_fwd_s4, b_r1_fwd_s5, b_r2_fwd_s5) consumed by the decode-stage equality comparator.
- Keeps a shadow pipeline (s3/s4/s5) of destination-register info fed from decode.
- Compares branch source registers against in-flight writers, picks forwarding sources, and raises a decode stall when the operand is not yet available.
- Sits beside the hazard unit in decode and obeys the global cache-miss freeze.

---
 rtl/branch_fwd_if.sv | 39 +++
 rtl/branch_fwd_ctrl.sv | 111 +++++++++++
 tb/tb_branch_fwd_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/branch_fwd_if.sv
// Decode-side bundle for branch_fwd_ctrl: branch/destination info in, forwarding selects and stall out.
// BFWD_STALL_CNT_EN adds the stall_cnt member.
interface branch_fwd_if #(
  parameter int unsigned REG_ADDR_BITS = 5
);
  logic                     mem_stall;
  logic                     is_branch_s2;
  logic [REG_ADDR_BITS-1:0] rs_s2;
  logic [REG_ADDR_BITS-1:0] rt_s2;
  logic [REG_ADDR_BITS-1:0] rd_s2;
  logic                     reg_we_s2;
  logic                     mem_rd_s2;
  logic                     b_r1_fwd_s4;
  logic                     b_r2_fwd_s4;
  logic                     b_r1_fwd_s5;
  logic                     b_r2_fwd_s5;
  logic                     b_stall;
`ifdef BFWD_STALL_CNT_EN
  logic [31:0]              stall_cnt;

  modport master (
    output mem_stall, is_branch_s2, rs_s2, rt_s2, rd_s2, reg_we_s2, mem_rd_s2,
    input  b_r1_fwd_s4, b_r2_fwd_s4, b_r1_fwd_s5, b_r2_fwd_s5, b_stall, stall_cnt
  );
  modport slave (
    input  mem_stall, is_branch_s2, rs_s2, rt_s2, rd_s2, reg_we_s2, mem_rd_s2,
    output b_r1_fwd_s4, b_r2_fwd_s4, b_r1_fwd_s5, b_r2_fwd_s5, b_stall, stall_cnt
  );
`else
  modport master (
    output mem_stall, is_branch_s2, rs_s2, rt_s2, rd_s2, reg_we_s2, mem_rd_s2,
    input  b_r1_fwd_s4, b_r2_fwd_s4, b_r1_fwd_s5, b_r2_fwd_s5, b_stall
  );
  modport slave (
    input  mem_stall, is_branch_s2, rs_s2, rt_s2, rd_s2, reg_we_s2, mem_rd_s2,
    output b_r1_fwd_s4, b_r2_fwd_s4, b_r1_fwd_s5, b_r2_fwd_s5, b_stall
  );
`endif
endinterface

// File: rtl/branch_fwd_ctrl.sv
// Branch-compare forwarding select and decode stall generator with an s3/s4/s5 shadow pipeline.
// Optional stall counter enabled by BFWD_STALL_CNT_EN.
module branch_fwd_ctrl #(
  parameter int unsigned REG_ADDR_BITS = 5,
  parameter int unsigned ZERO_REG      = 0
) (
  input  logic         clk,
  input  logic         rst,
  branch_fwd_if.slave  bus
);
  localparam int unsigned RW = REG_ADDR_BITS;
  localparam logic [RW-1:0] ZERO_RD = RW'(ZERO_REG);

  typedef struct packed {
    logic          vld;
    logic          we;
    logic          ld;
    logic [RW-1:0] rd;
  } stage_t;

  stage_t s3_q, s4_q, s5_q;
  stage_t s3_d, s4_d, s5_d;

  logic wr_s3, wr_s4, wr_s5;
  logic m1_s3, m1_s4, m1_s5;
  logic m2_s3, m2_s4, m2_s5;
  logic haz;
  logic stall_c;
  logic r1_fwd_s4_c, r2_fwd_s4_c, r1_fwd_s5_c, r2_fwd_s5_c;

  // Hazard detection and forwarding selection from the current shadow state
  always_comb begin
    wr_s3 = s3_q.vld & s3_q.we & (s3_q.rd != ZERO_RD);
    wr_s4 = s4_q.vld & s4_q.we & (s4_q.rd != ZERO_RD);
    wr_s5 = s5_q.vld & s5_q.we & (s5_q.rd != ZERO_RD);

    m1_s3 = wr_s3 & (s3_q.rd == bus.rs_s2);
    m1_s4 = wr_s4 & (s4_q.rd == bus.rs_s2);
    m1_s5 = wr_s5 & (s5_q.rd == bus.rs_s2);
    m2_s3 = wr_s3 & (s3_q.rd == bus.rt_s2);
    m2_s4 = wr_s4 & (s4_q.rd == bus.rt_s2);
    m2_s5 = wr_s5 & (s5_q.rd == bus.rt_s2);

    // s3 has no result yet; a load in s4 only has data once it reaches s5
    haz = bus.is_branch_s2 & (m1_s3 | m2_s3 | ((m1_s4 | m2_s4) & s4_q.ld));

    // Outputs forced low while reset is held, since the state is not cleared until the edge
    stall_c     = ~rst & haz;
    r1_fwd_s4_c = ~rst & bus.is_branch_s2 & m1_s4 & ~s4_q.ld;
    r2_fwd_s4_c = ~rst & bus.is_branch_s2 & m2_s4 & ~s4_q.ld;
    r1_fwd_s5_c = ~rst & bus.is_branch_s2 & m1_s5 & ~r1_fwd_s4_c;
    r2_fwd_s5_c = ~rst & bus.is_branch_s2 & m2_s5 & ~r2_fwd_s4_c;
  end

  // Shadow pipeline advance; a stalled decode slot enters s3 as a bubble
  always_comb begin
    s3_d = s3_q;
    s4_d = s4_q;
    s5_d = s5_q;
    if (!bus.mem_stall) begin
      s5_d = s4_q;
      s4_d = s3_q;
      if (stall_c) begin
        s3_d = '0;
      end else begin
        s3_d = '{vld: 1'b1, we: bus.reg_we_s2, ld: bus.mem_rd_s2, rd: bus.rd_s2};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_q <= '0;
      s4_q <= '0;
      s5_q <= '0;
    end else begin
      s3_q <= s3_d;
      s4_q <= s4_d;
      s5_q <= s5_d;
    end
  end

  assign bus.b_stall     = stall_c;
  assign bus.b_r1_fwd_s4 = r1_fwd_s4_c;
  assign bus.b_r2_fwd_s4 = r2_fwd_s4_c;
  assign bus.b_r1_fwd_s5 = r1_fwd_s5_c;
  assign bus.b_r2_fwd_s5 = r2_fwd_s5_c;

`ifdef BFWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles in which a real bubble is inserted
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && !bus.mem_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_branch_fwd_ctrl.sv
// Scoreboard bench for branch_fwd_ctrl: directed decode vectors push expected selects/stall,
// a negedge monitor pops and compares. Checks stall_cnt when BFWD_STALL_CNT_EN is defined.
module tb_branch_fwd_ctrl;
  logic clk;
  logic rst;

  branch_fwd_if #(.REG_ADDR_BITS(5)) bus ();

  branch_fwd_ctrl #(.REG_ADDR_BITS(5), .ZERO_REG(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  exp;   // {stall, r1_s4, r2_s4, r1_s5, r2_s5}
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] cnt_model = 32'd0;

  task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, fld, act, want);
    end
  endtask

  // Monitor: every cycle presents a result; compare it with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check(e.name, "b_stall",     32'(bus.b_stall),     32'(e.exp[4]));
        check(e.name, "b_r1_fwd_s4", 32'(bus.b_r1_fwd_s4), 32'(e.exp[3]));
        check(e.name, "b_r2_fwd_s4", 32'(bus.b_r2_fwd_s4), 32'(e.exp[2]));
        check(e.name, "b_r1_fwd_s5", 32'(bus.b_r1_fwd_s5), 32'(e.exp[1]));
        check(e.name, "b_r2_fwd_s5", 32'(bus.b_r2_fwd_s5), 32'(e.exp[0]));
`ifdef BFWD_STALL_CNT_EN
        check(e.name, "stall_cnt", bus.stall_cnt, e.cnt);
`endif
      end
    end
  end

  task automatic step(input string nm, input bit r, input bit ms, input bit br,
                      input int rs, input int rt, input int rd, input bit we, input bit ld,
                      input logic [4:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.mem_stall    = ms;
    bus.is_branch_s2 = br;
    bus.rs_s2        = 5'(rs);
    bus.rt_s2        = 5'(rt);
    bus.rd_s2        = 5'(rd);
    bus.reg_we_s2    = we;
    bus.mem_rd_s2    = ld;
    e.name = nm;
    e.exp  = exp;
    e.cnt  = cnt_model;
    sb_q.push_back(e);
    if (r) cnt_model = 32'd0;
    else if (exp[4] && !ms && cnt_model != 32'hFFFF_FFFF) cnt_model = cnt_model + 32'd1;
  endtask

  task automatic nop(input string nm);
    step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.mem_stall = 1'b0; bus.is_branch_s2 = 1'b0;
    bus.rs_s2 = '0; bus.rt_s2 = '0; bus.rd_s2 = '0;
    bus.reg_we_s2 = 1'b0; bus.mem_rd_s2 = 1'b0;

    step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    nop("post_rst");

    // ALU producer then dependent beq r3,r4
    step("alu_issue",     0, 0, 0, 0, 0, 3, 1, 0, 5'b00000);
    step("alu_use_stall", 0, 0, 1, 3, 4, 0, 0, 0, 5'b10000);
    step("alu_use_fwd4",  0, 0, 1, 3, 4, 0, 0, 0, 5'b01000);
    nop("flush_a0"); nop("flush_a1");

    // Load r5 then beq r0,r5
    step("ld_issue",  0, 0, 0, 0, 0, 5, 1, 1, 5'b00000);
    step("ld_stall1", 0, 0, 1, 0, 5, 0, 0, 0, 5'b10000);
    step("ld_stall2", 0, 0, 1, 0, 5, 0, 0, 0, 5'b10000);
    step("ld_fwd5",   0, 0, 1, 0, 5, 0, 0, 0, 5'b00001);
    nop("flush_b0"); nop("flush_b1"); nop("flush_b2");

    // Two writers of r7; youngest (s4) wins for both sources
    step("w7a", 0, 0, 0, 0, 0, 7, 1, 0, 5'b00000);
    step("w7b", 0, 0, 0, 0, 0, 7, 1, 0, 5'b00000);
    nop("w7_gap");
    step("prio_s4", 0, 0, 1, 7, 7, 0, 0, 0, 5'b01100);
    nop("flush_c0"); nop("flush_c1");

    // Writer of r0 never forwards or stalls
    step("w_r0",   0, 0, 0, 0, 0, 0, 1, 0, 5'b00000);
    step("r0_br3", 0, 0, 1, 0, 0, 0, 0, 0, 5'b00000);
    step("r0_br4", 0, 0, 1, 0, 0, 0, 0, 0, 5'b00000);
    step("r0_br5", 0, 0, 1, 0, 0, 0, 0, 0, 5'b00000);
    nop("flush_d0"); nop("flush_d1");

    // Dependent ALU op frozen by mem_stall for three cycles
    step("alu9",     0, 0, 0, 0, 0, 9, 1, 0, 5'b00000);
    step("frz0",     0, 1, 1, 9, 1, 0, 0, 0, 5'b10000);
    step("frz1",     0, 1, 1, 9, 1, 0, 0, 0, 5'b10000);
    step("frz2",     0, 1, 1, 9, 1, 0, 0, 0, 5'b10000);
    step("frz_rel",  0, 0, 1, 9, 1, 0, 0, 0, 5'b10000);
    step("frz_fwd4", 0, 0, 1, 9, 1, 0, 0, 0, 5'b01000);
    nop("flush_e0"); nop("flush_e1"); nop("flush_e2");

    // Fresh reset so the load-use stall count starts from zero
    step("rst_mid", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    nop("post_rst2");
    step("ld2_issue",  0, 0, 0, 0, 0, 5, 1, 1, 5'b00000);
    step("ld2_stall1", 0, 0, 1, 0, 5, 0, 0, 0, 5'b10000);
    step("ld2_stall2", 0, 0, 1, 0, 5, 0, 0, 0, 5'b10000);
    step("ld2_fwd5",   0, 0, 1, 0, 5, 0, 0, 0, 5'b00001);

    // Reset asserted in the middle of a load-use stall
    step("ld6_issue",    0, 0, 0, 0, 0, 6, 1, 1, 5'b00000);
    step("ld6_stall",    0, 0, 1, 6, 6, 0, 0, 0, 5'b10000);
    step("rst_in_stall", 1, 0, 1, 6, 6, 0, 0, 0, 5'b00000);
    step("after_rst",    0, 0, 1, 6, 6, 0, 0, 0, 5'b00000);
    nop("tail");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
